// File: rtl/alu16_sequencer.sv
// Two-pass 16-bit sequencer for the shared 8-bit ALU: splits each wide op into byte passes
// (lo/hi, or hi/lo for right shifts), chaining carry through the ALU's own carry flag.

`ifndef OP_ADD
`define OP_ADD 4'd0
`define OP_ADC 4'd1
`define OP_SUB 4'd2
`define OP_SBC 4'd3
`define OP_AND 4'd4
`define OP_OR  4'd5
`define OP_XOR 4'd6
`define OP_MOV 4'd7
`define OP_CMP 4'd8
`define OP_NEG 4'd0
`define OP_COM 4'd1
`define OP_LSL 4'd2
`define OP_LSR 4'd3
`define OP_ROL 4'd4
`define OP_ROR 4'd5
`define OP_RLC 4'd6
`define OP_RRC 4'd7
`endif

module alu16_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        wide,
  input  logic        single_op,
  input  logic [3:0]  op,
  input  logic [15:0] opa,
  input  logic [15:0] opb,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] result,
  output logic [3:0]  flags,
  output logic        alu_cs_in,
  output logic        alu_cs_out,
  output logic        alu_cs_flags,
  output logic        alu_single,
  output logic [3:0]  alu_operator,
  output logic [7:0]  alu_value1,
  output logic [7:0]  alu_value2,
  input  logic [7:0]  alu_bus,
  input  logic [3:0]  alu_flags
);

  typedef enum logic [1:0] {IDLE, P1, P2, FIN} state_t;

  state_t      state, state_nxt;
  logic [3:0]  op_q;
  logic        single_q, wide_q, rshift_q, reject_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  byte_p1;
  logic        use_hi;
  logic [15:0] res_fin;
  logic [3:0]  flags_fin;
  logic        unused_alu_zn;

  // ALU z and n are recomputed here over the full width.
  assign unused_alu_zn = ^alu_flags[1:0];

  function automatic logic is_illegal_wide(input logic s, input logic [3:0] o);
    return s && (o == `OP_NEG || o == `OP_ROL || o == `OP_ROR);
  endfunction

  function automatic logic is_rshift(input logic s, input logic [3:0] o);
    return s && (o == `OP_LSR || o == `OP_RRC);
  endfunction

  function automatic logic [3:0] pass_op(input logic s, input logic w, input logic first,
                                         input logic [3:0] o);
    logic [3:0] r;
    r = o;
    if (w) begin
      if (!s) begin
        if (o == `OP_CMP)                r = first ? `OP_SUB : `OP_SBC;
        else if (!first && o == `OP_ADD) r = `OP_ADC;
        else if (!first && o == `OP_SUB) r = `OP_SBC;
      end else if (!first) begin
        if (o == `OP_LSL)      r = `OP_RLC;
        else if (o == `OP_LSR) r = `OP_RRC;
      end
    end
    return r;
  endfunction

  // Right shifts walk hi byte first so the shifted-out bit lands in the lo byte.
  assign use_hi = (state == P1) ? rshift_q : ~rshift_q;

  always_comb begin
    if (!wide_q)       res_fin = {8'h00, alu_bus};
    else if (rshift_q) res_fin = {byte_p1, alu_bus};
    else               res_fin = {alu_bus, byte_p1};
    flags_fin = {alu_flags[3], alu_flags[2], (res_fin == 16'h0000),
                 (wide_q ? res_fin[15] : res_fin[7])};
  end

  always_comb begin
    state_nxt    = state;
    busy         = (state != IDLE);
    done         = 1'b0;
    err          = 1'b0;
    alu_cs_in    = 1'b0;
    alu_cs_out   = 1'b0;
    alu_cs_flags = 1'b0;
    alu_single   = 1'b0;
    alu_operator = 4'h0;
    alu_value1   = 8'h00;
    alu_value2   = 8'h00;
    case (state)
      IDLE: if (start) state_nxt = (wide && is_illegal_wide(single_op, op)) ? FIN : P1;
      P1, P2: begin
        state_nxt    = (state == P1 && wide_q) ? P2 : FIN;
        alu_cs_in    = 1'b1;
        alu_cs_out   = 1'b1;
        alu_cs_flags = 1'b1;
        alu_single   = single_q;
        alu_operator = pass_op(single_q, wide_q, (state == P1), op_q);
        alu_value1   = use_hi ? a_q[15:8] : a_q[7:0];
        alu_value2   = use_hi ? b_q[15:8] : b_q[7:0];
      end
      FIN: begin
        state_nxt = IDLE;
        done      = ~reject_q;
        err       = reject_q;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= 4'h0;
      single_q <= 1'b0;
      wide_q   <= 1'b0;
      rshift_q <= 1'b0;
      reject_q <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      byte_p1  <= 8'h00;
      result   <= 16'h0000;
      flags    <= 4'h0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          op_q     <= op;
          single_q <= single_op;
          wide_q   <= wide;
          rshift_q <= wide && is_rshift(single_op, op);
          reject_q <= wide && is_illegal_wide(single_op, op);
          a_q      <= opa;
          b_q      <= opb;
        end
        P1: begin
          if (wide_q) begin
            byte_p1 <= alu_bus;
          end else begin
            result <= res_fin;
            flags  <= flags_fin;
          end
        end
        P2: begin
          result <= res_fin;
          flags  <= flags_fin;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_sequencer.sv
// Directed bench for alu16_sequencer with a behavioural 8-bit ALU that keeps its own carry.
module tb_alu16_sequencer;

  localparam logic [3:0] C_ADD = 4'd0, C_ADC = 4'd1, C_SUB = 4'd2, C_SBC = 4'd3,
                         C_AND = 4'd4, C_OR  = 4'd5, C_XOR = 4'd6, C_MOV = 4'd7, C_CMP = 4'd8;
  localparam logic [3:0] C_NEG = 4'd0, C_COM = 4'd1, C_LSL = 4'd2, C_LSR = 4'd3,
                         C_ROL = 4'd4, C_ROR = 4'd5, C_RLC = 4'd6, C_RRC = 4'd7;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0, wide = 1'b0, single_op = 1'b0;
  logic [3:0]  op = 4'h0;
  logic [15:0] opa = 16'h0, opb = 16'h0;
  logic        busy, done, err;
  logic [15:0] result;
  logic [3:0]  flags;
  logic        alu_cs_in, alu_cs_out, alu_cs_flags, alu_single;
  logic [3:0]  alu_operator;
  logic [7:0]  alu_value1, alu_value2;
  logic [7:0]  alu_bus;
  logic [3:0]  alu_flags;

  int errors = 0;
  int checks = 0;

  alu16_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .wide(wide), .single_op(single_op),
    .op(op), .opa(opa), .opb(opb), .busy(busy), .done(done), .err(err),
    .result(result), .flags(flags), .alu_cs_in(alu_cs_in), .alu_cs_out(alu_cs_out),
    .alu_cs_flags(alu_cs_flags), .alu_single(alu_single), .alu_operator(alu_operator),
    .alu_value1(alu_value1), .alu_value2(alu_value2), .alu_bus(alu_bus), .alu_flags(alu_flags)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; carry persists between passes as in the real part.
  logic       alu_c = 1'b0;
  logic [7:0] m_r;
  logic       m_c, m_v;
  logic [8:0] t;

  always_comb begin
    t   = 9'h000;
    m_r = 8'h00;
    m_c = alu_c;
    m_v = 1'b0;
    if (!alu_single) begin
      case (alu_operator)
        C_ADD, C_ADC: begin
          t   = {1'b0, alu_value1} + {1'b0, alu_value2} + ((alu_operator == C_ADC) ? {8'h00, alu_c} : 9'h000);
          m_r = t[7:0]; m_c = t[8];
          m_v = (alu_value1[7] == alu_value2[7]) && (m_r[7] != alu_value1[7]);
        end
        C_SUB, C_SBC, C_CMP: begin
          t   = {1'b0, alu_value1} - {1'b0, alu_value2} - ((alu_operator == C_SBC) ? {8'h00, alu_c} : 9'h000);
          m_r = t[7:0]; m_c = t[8];
          m_v = (alu_value1[7] != alu_value2[7]) && (m_r[7] != alu_value1[7]);
        end
        C_AND: begin m_r = alu_value1 & alu_value2; m_c = 1'b0; end
        C_OR:  begin m_r = alu_value1 | alu_value2; m_c = 1'b0; end
        C_XOR: begin m_r = alu_value1 ^ alu_value2; m_c = 1'b0; end
        C_MOV: begin m_r = alu_value2; m_c = 1'b0; end
        default: m_r = 8'h00;
      endcase
    end else begin
      case (alu_operator)
        C_NEG: begin m_r = 8'h00 - alu_value1; m_c = (alu_value1 != 8'h00); m_v = (alu_value1 == 8'h80); end
        C_COM: begin m_r = ~alu_value1; m_c = 1'b1; end
        C_LSL: begin m_r = {alu_value1[6:0], 1'b0};          m_c = alu_value1[7]; end
        C_LSR: begin m_r = {1'b0, alu_value1[7:1]};          m_c = alu_value1[0]; end
        C_ROL: begin m_r = {alu_value1[6:0], alu_value1[7]}; m_c = alu_value1[7]; end
        C_ROR: begin m_r = {alu_value1[0], alu_value1[7:1]}; m_c = alu_value1[0]; end
        C_RLC: begin m_r = {alu_value1[6:0], alu_c};         m_c = alu_value1[7]; end
        C_RRC: begin m_r = {alu_c, alu_value1[7:1]};         m_c = alu_value1[0]; end
        default: m_r = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) if (alu_cs_in) alu_c <= m_c;

  assign alu_bus   = alu_cs_out   ? m_r : 8'h00;
  assign alu_flags = alu_cs_flags ? {m_c, m_v, (m_r == 8'h00), m_r[7]} : 4'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Issues one request and follows it to done/err, bounded to 8 cycles.
  task automatic run_op(input logic w, input logic s, input logic [3:0] o,
                        input logic [15:0] a, input logic [15:0] b, input logic pulse,
                        output int lat, output int ncs, output int nbusy,
                        output logic [3:0] op1, output logic [3:0] op2, output logic [7:0] v1first,
                        output logic got_done, output logic got_err);
    @(negedge clk);
    wide = w; single_op = s; op = o; opa = a; opb = b; start = 1'b1;
    lat = 0; ncs = 0; nbusy = 0; op1 = 4'h0; op2 = 4'h0; v1first = 8'h00;
    got_done = 1'b0; got_err = 1'b0;
    while (lat < 8 && !got_done && !got_err) begin
      @(negedge clk);
      lat++;
      start = pulse && (lat < 3);
      if (pulse) opa = ~a;
      if (busy) nbusy++;
      if (alu_cs_in) begin
        ncs++;
        if (ncs == 1) begin op1 = alu_operator; v1first = alu_value1; end
        else op2 = alu_operator;
      end
      got_done = done;
      got_err  = err;
    end
    start = 1'b0;
    opa = a;
  endtask

  int lat, ncs, nbusy, cnt;
  logic [3:0] op1, op2;
  logic [7:0] v1f;
  logic gd, ge;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    chk("rst_alu_cs", 32'({alu_cs_in, alu_cs_out, alu_cs_flags, alu_single}), 32'd0);
    chk("rst_alu_bus", 32'({alu_operator, alu_value1, alu_value2}), 32'd0);
    reset_n = 1'b1;

    run_op(1'b1, 1'b0, C_ADD, 16'h00FF, 16'h0001, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("add_lat", 32'(lat), 32'd3);
    chk("add_done", 32'({gd, ge}), 32'b10);
    chk("add_ops", 32'({op1, op2}), 32'({C_ADD, C_ADC}));
    chk("add_ncs", 32'(ncs), 32'd2);
    chk("add_result", 32'(result), 32'h0100);
    chk("add_flags", 32'(flags), 32'b0000);

    run_op(1'b1, 1'b0, C_SUB, 16'h0100, 16'h0001, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("sub_result", 32'(result), 32'h00FF);
    chk("sub_flags", 32'(flags), 32'b0000);

    run_op(1'b1, 1'b0, C_CMP, 16'h1234, 16'h1234, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("cmp_ops", 32'({op1, op2}), 32'({C_SUB, C_SBC}));
    chk("cmp_result", 32'(result), 32'h0000);
    chk("cmp_flags", 32'(flags), 32'b0010);

    run_op(1'b1, 1'b1, C_LSR, 16'h0003, 16'h0000, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("lsr_first_byte", 32'(v1f), 32'h00);
    chk("lsr_ops", 32'({op1, op2}), 32'({C_LSR, C_RRC}));
    chk("lsr_result", 32'(result), 32'h0001);
    chk("lsr_flags", 32'(flags), 32'b1000);

    run_op(1'b1, 1'b1, C_LSL, 16'h8000, 16'h0000, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("lsl_ops", 32'({op1, op2}), 32'({C_LSL, C_RLC}));
    chk("lsl_result", 32'(result), 32'h0000);
    chk("lsl_flags", 32'(flags), 32'b1010);

    // Hi-byte pass is zero but the full result is not: zero flag must stay clear.
    run_op(1'b1, 1'b0, C_AND, 16'h00F0, 16'h0030, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("and_result", 32'(result), 32'h0030);
    chk("and_flags", 32'(flags), 32'b0000);

    run_op(1'b0, 1'b1, C_NEG, 16'hAB01, 16'h0000, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("neg8_lat", 32'(lat), 32'd2);
    chk("neg8_ncs_op", 32'({ncs[3:0], op1}), 32'({4'd1, C_NEG}));
    chk("neg8_result", 32'(result), 32'h00FF);
    chk("neg8_flags", 32'(flags), 32'b1001);

    run_op(1'b1, 1'b1, C_NEG, 16'h0001, 16'h0000, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("negw_err", 32'({gd, ge}), 32'b01);
    chk("negw_lat", 32'(lat), 32'd1);
    chk("negw_no_alu", 32'(ncs), 32'd0);
    chk("negw_result_held", 32'(result), 32'h00FF);
    chk("negw_flags_held", 32'(flags), 32'b1001);

    run_op(1'b0, 1'b0, C_ADD, 16'h12FF, 16'h3401, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("add8_result", 32'(result), 32'h0000);
    chk("add8_flags", 32'(flags), 32'b1010);

    run_op(1'b1, 1'b0, C_ADD, 16'h0102, 16'h0304, 1'b1, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("pulse_lat", 32'(lat), 32'd3);
    chk("pulse_busy_cycles", 32'(nbusy), 32'd3);
    chk("pulse_result", 32'(result), 32'h0406);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done || err || busy) cnt++;
    end
    chk("pulse_no_extra", 32'(cnt), 32'd0);

    @(negedge clk);
    wide = 1'b1; single_op = 1'b0; op = C_ADD; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_in_p2", 32'(alu_cs_in), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_cs", 32'({alu_cs_in, alu_cs_out, alu_cs_flags}), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("abort_no_done", 32'(cnt), 32'd0);

    run_op(1'b1, 1'b0, C_ADD, 16'h1111, 16'h2222, 1'b0, lat, ncs, nbusy, op1, op2, v1f, gd, ge);
    chk("post_abort_done", 32'({gd, lat[3:0]}), 32'({1'b1, 4'd3}));
    chk("post_abort_result", 32'(result), 32'h3333);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
